parity_frame_tx: RTL and testbench

Serial frame transmitter paired with the even/odd parity checker. Accepts a DATA_W-bit word on a valid/ready handshake, computes its parity bit, and shifts out a frame of start bit, data LSB first, parity bit and stop bit on a single line. Each bit is held for CLKS_PER_BIT clocks. Sits on the transmit side of the nibble link; the receive side recovers the word and checks it with the even/odd checker.

---
 rtl/parity_frame_tx.sv | 129 ++++++++++++
 tb/tb_parity_frame_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial frame transmitter.
// Frame = start(0), data LSB first, parity, stop(1); each bit CLKS_PER_BIT clocks.
module parity_frame_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic          ODD_BIT  = (ODD_PARITY != 0);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_par;

  logic              w_accept;
  logic              w_cnt_last;
  logic              w_par;
  logic [DATA_W-1:0] w_shift_nx;

  assign in_ready   = (r_state == S_IDLE) && rst_n;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_par      = (^in_data) ^ ODD_BIT;
  assign w_shift_nx = r_shift >> 1;

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign parity_out = r_par;

  // Frame FSM; tx is registered as the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= in_data;
            r_par   <= w_par;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              r_tx    <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_shift <= w_shift_nx;
              r_tx    <= w_shift_nx[0];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: random + directed frames, scoreboard of words
// against a frame-level model; second instance covers odd parity at 1 clk/bit.
module tb_parity_frame_tx;

  localparam int DW  = 4;
  localparam int CPB = 4;
  localparam int ODD = 0;
  localparam int NB  = DW + 3;
  localparam int L   = NB * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, busy, parity_out;

  logic [3:0]    o_data = '0;
  logic          o_valid = 1'b0;
  logic          o_ready, o_tx, o_busy, o_par;

  parity_frame_tx #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(ODD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .busy(busy), .parity_out(parity_out)
  );

  parity_frame_tx #(
    .DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(1)
  ) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .in_data(o_data), .in_valid(o_valid), .in_ready(o_ready),
    .tx(o_tx), .busy(o_busy), .parity_out(o_par)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w;
    logic          p;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t nw;
  exp_t cur;
  int   cyc = 0;
  int   m_left = 0;
  int   n_acc = 0;
  logic m_par = 1'b0;
  bit   rst_seen = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic samp [L];
  int   k = 0;
  bit   in_frame = 1'b0;

  function automatic logic ref_par(input logic [DW-1:0] w);
    return 1'(($countones(w) + ODD) % 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Frame-level model: a frame occupies L cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_left   = 0;
      m_par    = 1'b0;
      rst_seen = 1'b1;
      sb.delete();
    end else begin
      rst_seen = 1'b0;
      if (m_left == 0 && in_valid) begin
        nw.w   = in_data;
        nw.p   = ref_par(in_data);
        nw.acc = cyc;
        sb.push_back(nw);
        m_par  = nw.p;
        m_left = L;
        n_acc++;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  task automatic finish_frame();
    logic          eb;
    logic [DW-1:0] dec;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)           eb = 1'b0;
      else if (b <= DW)     eb = cur.w[b-1];
      else if (b == DW + 1) eb = cur.p;
      else                  eb = 1'b1;
      for (int c = 0; c < CPB; c++)
        check($sformatf("tx_bit%0d", b), 32'(samp[b*CPB+c]), 32'(eb));
    end
    for (int i = 0; i < DW; i++)
      dec[i] = samp[(i+1)*CPB + CPB/2];
    check("decoded_word", 32'(dec), 32'(cur.w));
  endtask

  // Monitor: per-cycle status checks, frame capture and scoreboard pop.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'((m_left == 0) && rst_n));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("parity_out", 32'(parity_out), 32'(m_par));
    if (rst_seen) begin
      in_frame = 1'b0;
      check("tx_reset", 32'(tx), 32'd1);
    end else if (in_frame) begin
      samp[k] = tx;
      k++;
      if (k == L) begin
        finish_frame();
        in_frame = 1'b0;
      end
    end else if (tx == 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_frame: got start bit want idle (cycle %0d)",
                 cyc);
      end else begin
        cur = sb.pop_front();
        check("start_cycle", 32'(cyc), 32'(cur.acc));
        samp[0]  = tx;
        k        = 1;
        in_frame = 1'b1;
      end
    end else if (sb.size() > 0 && cyc > sb[0].acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_frame: got idle want start of %0h (cycle %0d)",
               sb[0].w, cyc);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int start;
    start    = n_acc;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && n_acc == start; i++) tick();
    if (n_acc == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept want accept of %0h", w);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic odd_frame(input logic [3:0] w);
    logic ob [7];
    logic p;
    p = 1'(($countones(w) + 1) % 2);
    ob[0] = 1'b0;
    for (int i = 0; i < 4; i++) ob[i+1] = w[i];
    ob[5] = p;
    ob[6] = 1'b1;
    o_data  = w;
    o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    @(negedge clk);
    check("odd_parity_out", 32'(o_par), 32'(p));
    for (int i = 0; i < 7; i++) begin
      check($sformatf("odd_tx%0d", i), 32'(o_tx), 32'(ob[i]));
      check("odd_busy", 32'(o_busy), 32'd1);
      @(negedge clk);
    end
    check("odd_idle_busy", 32'(o_busy), 32'd0);
    check("odd_idle_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("odd_reset_tx", 32'(o_tx), 32'd1);
    check("odd_reset_par", 32'(o_par), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    odd_frame(4'd7);
    odd_frame(4'd6);
    tick();

    send(4'd6, 1'b0);
    send(4'd7, 1'b0);
    send(4'd11, 1'b0);
    send(4'd3, 1'b0);
    send(4'd10, 1'b0);
    send(4'd14, 1'b1);
    send(4'd3, 1'b0);

    send(4'd9, 1'b0);
    repeat (8) tick();
    in_data = 4'd6;
    repeat (16) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;

    send(4'd14, 1'b0);
    repeat (8) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    send(4'd10, 1'b0);

    repeat (30) begin
      logic [DW-1:0] w;
      bit            hold;
      w    = DW'($urandom);
      hold = 1'($urandom % 2);
      send(w, hold);
      if ($urandom % 3 == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        in_data = DW'($urandom);
      end
      if (!hold) repeat ($urandom_range(0, 3)) tick();
    end

    in_valid = 1'b0;
    repeat (L + 5) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
